// File: rtl/pwm_capture.sv
// PWM speed/direction capture monitor: measures period and high time of the PWM
// line, quantizes duty, reports stuck lines by timeout and debounces direction.
module pwm_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 5000,
    parameter int DIR_STABLE  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_in,
    input  logic        dir_a,
    input  logic        dir_b,
    output logic [11:0] high_cnt,
    output logic [11:0] period_cnt,
    output logic [2:0]  duty_code,
    output logic        sample_valid,
    output logic        stuck,
    output logic        range_err,
    output logic [1:0]  dir_state,
    output logic        dir_change
);

    localparam int IDLE_W = $clog2(TIMEOUT);
    localparam int STAB_W = $clog2(DIR_STABLE + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DIR_STABLE - 1);
    localparam logic [11:0]       CNT_MAX  = 12'hFFF;

    typedef enum logic [1:0] {IDLE, MEAS, STUCK} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] pwmSync_q, dirASync_q, dirBSync_q;
    logic        pwmPrev_q;
    logic [1:0]  dirPrev_q;
    logic [11:0] perCtr_q, perCtr_d, hiCtr_q, hiCtr_d;
    logic        perOvf_q, perOvf_d;
    logic [IDLE_W-1:0] idleCtr_q, idleCtr_d;
    logic [11:0] highCnt_q, highCnt_d, periodCnt_q, periodCnt_d;
    logic        pendValid_q, pendValid_d, pendStuck_q, pendStuck_d;
    logic        pendLevel_q, pendLevel_d;
    logic [2:0]  duty_q, duty_d;
    logic        sampleValid_q, sampleValid_d, stuck_q, stuck_d;
    logic        rangeErr_q, rangeErr_d;
    logic [STAB_W-1:0] stableCtr_q, stableCtr_d;
    logic [1:0]  dirState_q, dirState_d;
    logic        dirChange_q, dirChange_d;

    logic        pwmLevel, rise, fall, timeoutHit;
    logic        acceptSample, rangeHit, stuckReport, countEn;
    logic [1:0]  dirPair;
    logic        dirUpdate;
    logic [14:0] h8, p1, p3, p5, p7;
    logic [2:0]  quantCode;

    assign pwmLevel   = pwmSync_q[SYNC_STAGES-1];
    assign rise       = pwmLevel & ~pwmPrev_q;
    assign fall       = ~pwmLevel & pwmPrev_q;
    assign timeoutHit = (idleCtr_q == IDLE_MAX);
    assign dirPair    = {dirBSync_q[SYNC_STAGES-1], dirASync_q[SYNC_STAGES-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A rise always takes priority over a timeout landing in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rise) state_d = MEAS; else if (timeoutHit) state_d = STUCK;
            MEAS:    if (!rise && timeoutHit) state_d = STUCK;
            STUCK:   if (rise) state_d = MEAS;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        acceptSample = 1'b0;
        rangeHit     = 1'b0;
        stuckReport  = 1'b0;
        countEn      = 1'b0;
        case (state_q)
            IDLE: stuckReport = timeoutHit && !rise;
            MEAS: begin
                countEn      = 1'b1;
                acceptSample = rise && !perOvf_q;
                rangeHit     = rise && perOvf_q;
                stuckReport  = timeoutHit && !rise;
            end
            default: ;
        endcase
    end

    always_comb begin
        perCtr_d = perCtr_q;
        hiCtr_d  = hiCtr_q;
        perOvf_d = perOvf_q;
        if (rise) begin
            perCtr_d = 12'd1;
            hiCtr_d  = 12'd1;
            perOvf_d = 1'b0;
        end else if (countEn) begin
            if (perCtr_q == CNT_MAX) perOvf_d = 1'b1;
            else                     perCtr_d = perCtr_q + 12'd1;
            if (pwmLevel && hiCtr_q != CNT_MAX) hiCtr_d = hiCtr_q + 12'd1;
        end

        idleCtr_d = idleCtr_q;
        if (rise || fall)            idleCtr_d = '0;
        else if (idleCtr_q != IDLE_MAX) idleCtr_d = idleCtr_q + IDLE_W'(1);
    end

    // 15-bit compare of 8*high against odd multiples of the period.
    always_comb begin
        h8 = {highCnt_q, 3'b000};
        p1 = {3'b000, periodCnt_q};
        p3 = p1 + {p1[13:0], 1'b0};
        p5 = p1 + {p1[12:0], 2'b00};
        p7 = {p1[11:0], 3'b000} - p1;
        if (h8 < p1)      quantCode = 3'd0;
        else if (h8 < p3) quantCode = 3'd1;
        else if (h8 < p5) quantCode = 3'd2;
        else if (h8 < p7) quantCode = 3'd3;
        else              quantCode = 3'd4;
    end

    // Counts land one cycle ahead of the strobe so duty is computed from them.
    always_comb begin
        highCnt_d   = highCnt_q;
        periodCnt_d = periodCnt_q;
        if (acceptSample) begin
            highCnt_d   = hiCtr_q;
            periodCnt_d = perCtr_q;
        end else if (stuckReport) begin
            highCnt_d   = '0;
            periodCnt_d = '0;
        end
        pendValid_d   = acceptSample | stuckReport;
        pendStuck_d   = stuckReport;
        pendLevel_d   = pwmLevel;
        rangeErr_d    = rangeHit;
        sampleValid_d = pendValid_q;
        stuck_d       = stuck_q;
        duty_d        = duty_q;
        if (pendValid_q) begin
            stuck_d = pendStuck_q;
            duty_d  = pendStuck_q ? (pendLevel_q ? 3'd4 : 3'd0) : quantCode;
        end
    end

    always_comb begin
        stableCtr_d = stableCtr_q;
        if (dirPair != dirPrev_q)        stableCtr_d = '0;
        else if (stableCtr_q != STAB_MAX) stableCtr_d = stableCtr_q + STAB_W'(1);
        dirUpdate   = (dirPair == dirPrev_q) && (stableCtr_q == STAB_MAX)
                      && (dirPair != dirState_q);
        dirState_d  = dirUpdate ? dirPair : dirState_q;
        dirChange_d = dirUpdate;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwmSync_q     <= '0;
            dirASync_q    <= '0;
            dirBSync_q    <= '0;
            pwmPrev_q     <= 1'b0;
            dirPrev_q     <= 2'b00;
            perCtr_q      <= '0;
            hiCtr_q       <= '0;
            perOvf_q      <= 1'b0;
            idleCtr_q     <= '0;
            highCnt_q     <= '0;
            periodCnt_q   <= '0;
            pendValid_q   <= 1'b0;
            pendStuck_q   <= 1'b0;
            pendLevel_q   <= 1'b0;
            duty_q        <= '0;
            sampleValid_q <= 1'b0;
            stuck_q       <= 1'b0;
            rangeErr_q    <= 1'b0;
            stableCtr_q   <= '0;
            dirState_q    <= 2'b00;
            dirChange_q   <= 1'b0;
        end else begin
            pwmSync_q     <= {pwmSync_q[SYNC_STAGES-2:0], pwm_in};
            dirASync_q    <= {dirASync_q[SYNC_STAGES-2:0], dir_a};
            dirBSync_q    <= {dirBSync_q[SYNC_STAGES-2:0], dir_b};
            pwmPrev_q     <= pwmLevel;
            dirPrev_q     <= dirPair;
            perCtr_q      <= perCtr_d;
            hiCtr_q       <= hiCtr_d;
            perOvf_q      <= perOvf_d;
            idleCtr_q     <= idleCtr_d;
            highCnt_q     <= highCnt_d;
            periodCnt_q   <= periodCnt_d;
            pendValid_q   <= pendValid_d;
            pendStuck_q   <= pendStuck_d;
            pendLevel_q   <= pendLevel_d;
            duty_q        <= duty_d;
            sampleValid_q <= sampleValid_d;
            stuck_q       <= stuck_d;
            rangeErr_q    <= rangeErr_d;
            stableCtr_q   <= stableCtr_d;
            dirState_q    <= dirState_d;
            dirChange_q   <= dirChange_d;
        end
    end

    assign high_cnt     = highCnt_q;
    assign period_cnt   = periodCnt_q;
    assign duty_code    = duty_q;
    assign sample_valid = sampleValid_q;
    assign stuck        = stuck_q;
    assign range_err    = rangeErr_q;
    assign dir_state    = dirState_q;
    assign dir_change   = dirChange_q;

endmodule
